// File: rtl/lap_timer_pkg.sv
// Shared types for the lap timer: FSM states, packed lap time and its ordering.
package lap_timer_pkg;

    localparam int TIME_W     = 7;
    localparam int LAP_TIME_W = 21;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_RUNNING,
        ST_CAPTURE
    } lap_state_t;

    typedef struct packed {
        logic [TIME_W-1:0] minutes;
        logic [TIME_W-1:0] seconds;
        logic [TIME_W-1:0] centis;
    } lap_time_t;

    // Field order makes the packed vector compare like a time value.
    function automatic logic lap_time_less(input lap_time_t a, input lap_time_t b);
        return LAP_TIME_W'(a) < LAP_TIME_W'(b);
    endfunction

endpackage

// File: rtl/lap_sequencer_if.sv
// Signals between the lap sequencer, the laser gate, the timer and the display stage.
interface lap_sequencer_if #(
    parameter int LAP_CNT_W = 8
);
    import lap_timer_pkg::*;

    logic                 laser_detector;
    logic [TIME_W-1:0]    cur_minutes;
    logic [TIME_W-1:0]    cur_seconds;
    logic [TIME_W-1:0]    cur_centis;
    logic                 timer_en;
    logic                 timer_clr;
    logic                 lap_strobe;
    logic [TIME_W-1:0]    last_minutes;
    logic [TIME_W-1:0]    last_seconds;
    logic [TIME_W-1:0]    last_centis;
    logic [TIME_W-1:0]    best_minutes;
    logic [TIME_W-1:0]    best_seconds;
    logic [TIME_W-1:0]    best_centis;
    logic                 best_valid;
    logic [LAP_CNT_W-1:0] lap_count;
    logic                 show_last;

    modport slave (
        input  laser_detector, cur_minutes, cur_seconds, cur_centis,
        output timer_en, timer_clr, lap_strobe,
               last_minutes, last_seconds, last_centis,
               best_minutes, best_seconds, best_centis,
               best_valid, lap_count, show_last
    );

    modport master (
        output laser_detector, cur_minutes, cur_seconds, cur_centis,
        input  timer_en, timer_clr, lap_strobe,
               last_minutes, last_seconds, last_centis,
               best_minutes, best_seconds, best_centis,
               best_valid, lap_count, show_last
    );

endinterface

// File: rtl/laser_debounce.sv
// Synchronises and debounces the raw laser gate; pulses crossing once per debounced beam break.
module laser_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic laser_raw,
    output logic crossing
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_q1;
    logic             sync_q2;
    logic             filt_level;
    logic [CNT_W-1:0] stable_cnt;

    // Idle beam is high, so everything resets to 1 to avoid a spurious crossing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1    <= 1'b1;
            sync_q2    <= 1'b1;
            filt_level <= 1'b1;
            stable_cnt <= '0;
            crossing   <= 1'b0;
        end else begin
            sync_q1  <= laser_raw;
            sync_q2  <= sync_q1;
            crossing <= 1'b0;
            if (sync_q2 == filt_level) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CNT_LAST) begin
                filt_level <= sync_q2;
                stable_cnt <= '0;
                crossing   <= filt_level;
            end else begin
                stable_cnt <= stable_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/lap_sequencer.sv
// Lap sequencer: turns debounced gate crossings into timer control and last/best lap capture.
module lap_sequencer
    import lap_timer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int HOLDOFF_SEC     = 5,
    parameter int SHOW_SEC        = 3,
    parameter int TIMEOUT_MIN     = 59,
    parameter int LAP_CNT_W       = 8
) (
    input  logic           master_clk,
    input  logic           rs_n,
    lap_sequencer_if.slave bus
);
    lap_state_t           state;
    lap_state_t           next_state;
    logic                 crossing;
    logic                 in_holdoff;
    logic                 timeout;
    logic                 capture_lap;
    logic                 update_best;
    logic                 timer_en;
    logic                 timer_clr;
    logic                 lap_strobe;
    logic                 best_valid;
    lap_time_t            cur_time;
    lap_time_t            last_time;
    lap_time_t            best_time;
    logic [LAP_CNT_W-1:0] lap_count;

    laser_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk      (master_clk),
        .rst_n    (rs_n),
        .laser_raw(bus.laser_detector),
        .crossing (crossing)
    );

    assign cur_time   = {bus.cur_minutes, bus.cur_seconds, bus.cur_centis};
    assign timeout    = (bus.cur_minutes == TIME_W'(TIMEOUT_MIN));
    assign in_holdoff = (bus.cur_minutes == '0) && (bus.cur_seconds < TIME_W'(HOLDOFF_SEC));

    always_ff @(posedge master_clk or negedge rs_n) begin
        if (!rs_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Timeout wins over a same-cycle crossing; crossings outside RUNNING (after IDLE) are dropped.
    always_comb begin
        next_state  = state;
        timer_en    = 1'b0;
        timer_clr   = 1'b0;
        lap_strobe  = 1'b0;
        capture_lap = 1'b0;
        update_best = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (crossing) begin
                    next_state = ST_START;
                end
            end
            ST_START: begin
                timer_clr  = 1'b1;
                next_state = ST_RUNNING;
            end
            ST_RUNNING: begin
                timer_en = 1'b1;
                if (timeout) begin
                    next_state = ST_IDLE;
                end else if (crossing && !in_holdoff) begin
                    capture_lap = 1'b1;
                    next_state  = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                timer_en    = 1'b1;
                timer_clr   = 1'b1;
                lap_strobe  = 1'b1;
                update_best = !best_valid || lap_time_less(last_time, best_time);
                next_state  = ST_RUNNING;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Best is judged one cycle after capture, against the freshly latched last lap.
    always_ff @(posedge master_clk or negedge rs_n) begin
        if (!rs_n) begin
            last_time  <= '0;
            best_time  <= '0;
            best_valid <= 1'b0;
            lap_count  <= '0;
        end else begin
            if (capture_lap) begin
                last_time <= cur_time;
                if (lap_count != '1) begin
                    lap_count <= lap_count + LAP_CNT_W'(1);
                end
            end
            if (update_best) begin
                best_time  <= last_time;
                best_valid <= 1'b1;
            end
        end
    end

    assign bus.timer_en     = timer_en;
    assign bus.timer_clr    = timer_clr;
    assign bus.lap_strobe   = lap_strobe;
    assign bus.last_minutes = last_time.minutes;
    assign bus.last_seconds = last_time.seconds;
    assign bus.last_centis  = last_time.centis;
    assign bus.best_minutes = best_time.minutes;
    assign bus.best_seconds = best_time.seconds;
    assign bus.best_centis  = best_time.centis;
    assign bus.best_valid   = best_valid;
    assign bus.lap_count    = lap_count;
    assign bus.show_last    = (lap_count != '0)
                            && (state == ST_RUNNING || state == ST_CAPTURE)
                            && (bus.cur_minutes == '0)
                            && (bus.cur_seconds < TIME_W'(SHOW_SEC));

endmodule

// File: tb/tb_lap_sequencer.sv
// Self-checking bench for lap_sequencer: expected laps queued at stimulus time, checked on lap_strobe.
module tb_lap_sequencer;

    localparam int TB_TIMEOUT_MIN = 59;

    typedef struct {
        logic [20:0] last;
        logic [20:0] best;
        int          count;
    } exp_lap_t;

    logic master_clk;
    logic rs_n;

    lap_sequencer_if #(.LAP_CNT_W(8)) bus ();

    lap_sequencer #(
        .DEBOUNCE_CYCLES(4),
        .HOLDOFF_SEC    (5),
        .SHOW_SEC       (3),
        .TIMEOUT_MIN    (TB_TIMEOUT_MIN),
        .LAP_CNT_W      (8)
    ) dut (
        .master_clk(master_clk),
        .rs_n      (rs_n),
        .bus       (bus)
    );

    initial master_clk = 1'b0;
    always #5 master_clk = ~master_clk;

    int          compared_count   = 0;
    int          mismatched_count = 0;
    exp_lap_t    sb_q[$];
    logic [20:0] model_best       = '0;
    bit          model_best_valid = 1'b0;
    int          model_count      = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared_count++;
        if (observed !== expected) begin
            mismatched_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput({tag, "_timer_en"},   32'(bus.timer_en), 0);
        checkOutput({tag, "_timer_clr"},  32'(bus.timer_clr), 0);
        checkOutput({tag, "_lap_strobe"}, 32'(bus.lap_strobe), 0);
        checkOutput({tag, "_show_last"},  32'(bus.show_last), 0);
        checkOutput({tag, "_best_valid"}, 32'(bus.best_valid), 0);
        checkOutput({tag, "_lap_count"},  32'(bus.lap_count), 0);
        checkOutput({tag, "_last"}, 32'({bus.last_minutes, bus.last_seconds, bus.last_centis}), 0);
        checkOutput({tag, "_best"}, 32'({bus.best_minutes, bus.best_seconds, bus.best_centis}), 0);
    endtask

    // One beam break (10 cycles low, 10 high) with cur_* held; lap results checked as they appear.
    task automatic applyStimulus(input int mins, input int secs, input int cents,
                                 input bit valid_lap, input bit timeout_mode,
                                 output int clr_seen, output int strobe_seen,
                                 output int en_at_clr, output int en_after_clr);
        exp_lap_t    e;
        exp_lap_t    pending;
        logic [20:0] lap;
        bit          prev_clr;
        bit          best_due;
        clr_seen     = 0;
        strobe_seen  = 0;
        en_at_clr    = -1;
        en_after_clr = -1;
        prev_clr     = 1'b0;
        best_due     = 1'b0;
        pending      = '{last: '0, best: '0, count: 0};
        bus.cur_minutes = 7'(mins);
        bus.cur_seconds = 7'(secs);
        bus.cur_centis  = 7'(cents);
        lap = {7'(mins), 7'(secs), 7'(cents)};
        if (valid_lap) begin
            model_count++;
            if (!model_best_valid || lap < model_best) model_best = lap;
            model_best_valid = 1'b1;
            e.last  = lap;
            e.best  = model_best;
            e.count = model_count;
            sb_q.push_back(e);
        end
        bus.laser_detector = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i == 10) bus.laser_detector = 1'b1;
            @(negedge master_clk);
            if (best_due) begin
                checkOutput("best_time", 32'({bus.best_minutes, bus.best_seconds, bus.best_centis}), 32'(pending.best));
                checkOutput("best_valid", 32'(bus.best_valid), 1);
                best_due = 1'b0;
            end
            if (prev_clr) en_after_clr = int'(bus.timer_en);
            prev_clr = bus.timer_clr;
            if (bus.timer_clr) begin
                clr_seen++;
                en_at_clr = int'(bus.timer_en);
            end
            if (bus.lap_strobe) begin
                strobe_seen++;
                if (sb_q.size() == 0) begin
                    checkOutput("sb_underflow", 32'(sb_q.size()), 1);
                end else begin
                    pending = sb_q.pop_front();
                    checkOutput("last_time", 32'({bus.last_minutes, bus.last_seconds, bus.last_centis}), 32'(pending.last));
                    checkOutput("lap_count", 32'(bus.lap_count), pending.count);
                    best_due = 1'b1;
                end
            end
            if (timeout_mode && i == 5) bus.cur_minutes = 7'(TB_TIMEOUT_MIN);
        end
    endtask

    int sl_min[4] = '{0, 0, 0, 1};
    int sl_sec[4] = '{0, 2, 3, 0};
    int sl_cen[4] = '{0, 99, 0, 0};
    int sl_exp[4] = '{1, 1, 0, 0};

    initial begin
        int clr_n, strb_n, en_at, en_after, busy_n;
        rs_n = 1'b0;
        bus.laser_detector = 1'b1;
        bus.cur_minutes = '0;
        bus.cur_seconds = '0;
        bus.cur_centis  = '0;
        repeat (3) @(negedge master_clk);
        check_all_zero("reset");
        rs_n = 1'b1;

        $display("[TB] idle with laser high");
        busy_n = 0;
        repeat (100) begin
            @(negedge master_clk);
            if (bus.timer_clr || bus.timer_en || bus.lap_strobe) busy_n++;
        end
        checkOutput("idle_activity", 32'(busy_n), 0);

        $display("[TB] short glitch");
        bus.laser_detector = 1'b0;
        repeat (3) @(negedge master_clk);
        bus.laser_detector = 1'b1;
        busy_n = 0;
        repeat (15) begin
            @(negedge master_clk);
            if (bus.timer_clr || bus.timer_en) busy_n++;
        end
        checkOutput("glitch_activity", 32'(busy_n), 0);

        $display("[TB] first crossing");
        applyStimulus(0, 0, 0, 1'b0, 1'b0, clr_n, strb_n, en_at, en_after);
        checkOutput("start_clr_count", 32'(clr_n), 1);
        checkOutput("start_en_at_clr", 32'(en_at), 0);
        checkOutput("start_en_after", 32'(en_after), 1);
        checkOutput("start_strobes", 32'(strb_n), 0);
        checkOutput("start_lap_count", 32'(bus.lap_count), 0);
        checkOutput("start_show_last", 32'(bus.show_last), 0);

        $display("[TB] holdoff and first lap");
        applyStimulus(0, 3, 50, 1'b0, 1'b0, clr_n, strb_n, en_at, en_after);
        checkOutput("holdoff_strobes", 32'(strb_n), 0);
        checkOutput("holdoff_clr", 32'(clr_n), 0);
        checkOutput("holdoff_timer_en", 32'(bus.timer_en), 1);
        applyStimulus(1, 2, 37, 1'b1, 1'b0, clr_n, strb_n, en_at, en_after);
        checkOutput("lap1_strobes", 32'(strb_n), 1);
        checkOutput("lap1_clr", 32'(clr_n), 1);
        checkOutput("lap1_en_at_clr", 32'(en_at), 1);

        for (int k = 0; k < 4; k++) begin
            bus.cur_minutes = 7'(sl_min[k]);
            bus.cur_seconds = 7'(sl_sec[k]);
            bus.cur_centis  = 7'(sl_cen[k]);
            #1;
            checkOutput($sformatf("show_last_%0d", k), 32'(bus.show_last), sl_exp[k]);
            @(negedge master_clk);
        end

        $display("[TB] best tracking");
        applyStimulus(0, 58, 10, 1'b1, 1'b0, clr_n, strb_n, en_at, en_after);
        checkOutput("lap2_strobes", 32'(strb_n), 1);
        applyStimulus(1, 0, 0, 1'b1, 1'b0, clr_n, strb_n, en_at, en_after);
        checkOutput("lap3_strobes", 32'(strb_n), 1);
        applyStimulus(0, 58, 10, 1'b1, 1'b0, clr_n, strb_n, en_at, en_after);
        checkOutput("lap4_strobes", 32'(strb_n), 1);
        checkOutput("lap4_count", 32'(bus.lap_count), 4);

        $display("[TB] timeout with same-cycle crossing");
        applyStimulus(1, 5, 0, 1'b0, 1'b1, clr_n, strb_n, en_at, en_after);
        checkOutput("timeout_strobes", 32'(strb_n), 0);
        checkOutput("timeout_clr", 32'(clr_n), 0);
        checkOutput("timeout_timer_en", 32'(bus.timer_en), 0);
        checkOutput("timeout_last", 32'({bus.last_minutes, bus.last_seconds, bus.last_centis}), 32'({7'd0, 7'd58, 7'd10}));
        checkOutput("timeout_best", 32'({bus.best_minutes, bus.best_seconds, bus.best_centis}), 32'(model_best));
        checkOutput("timeout_count", 32'(bus.lap_count), 4);

        $display("[TB] reset while running");
        applyStimulus(0, 1, 0, 1'b0, 1'b0, clr_n, strb_n, en_at, en_after);
        checkOutput("restart_timer_en", 32'(bus.timer_en), 1);
        checkOutput("restart_show_last", 32'(bus.show_last), 1);
        rs_n = 1'b0;
        #1;
        check_all_zero("midreset");
        checkOutput("sb_drained", 32'(sb_q.size()), 0);
        @(negedge master_clk);
        rs_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared_count, mismatched_count);
        $finish;
    end

endmodule
